// File: rtl/result_fifo_pkg.sv
// Shared constants and the stored entry layout for the result FIFO.
package result_fifo_pkg;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] result;
  } entry_t;
endpackage

// File: rtl/result_fifo_ptr.sv
// Modulo-DEPTH pointer register with synchronous reset and advance enable.
module result_fifo_ptr
  import result_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  output logic [PTR_W-1:0] o_ptr
);
  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_adv)
      r_ptr <= (r_ptr == PTR_W'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/result_fifo_4bit.sv
// Drop-on-full FIFO buffering {op, result} from the mux stage with a valid/ready output.
// Optional RESULT_FIFO_STATS_EN adds drop_cnt and max_count outputs.
module result_fifo_4bit
  import result_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_op,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              in_drop
`ifdef RESULT_FIFO_STATS_EN
  ,
  output logic [7:0]        drop_cnt,
  output logic [CNT_W-1:0]  max_count
`endif
);
  entry_t           r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_drop;
  logic [PTR_W-1:0] w_rd_ptr, w_wr_ptr;
  logic             w_pop, w_push, w_drop;
  logic [CNT_W-1:0] w_count_nxt;
  entry_t           w_head;

  // A full FIFO may still accept when the head leaves in the same cycle.
  assign w_pop  = out_valid & out_ready;
  assign w_push = in_valid & (~full | w_pop);
  assign w_drop = in_valid & ~w_push;

  result_fifo_ptr u_rd_ptr (.clk(clk), .rst(rst), .i_adv(w_pop),  .o_ptr(w_rd_ptr));
  result_fifo_ptr u_wr_ptr (.clk(clk), .rst(rst), .i_adv(w_push), .o_ptr(w_wr_ptr));

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) r_mem[w_wr_ptr] <= '{op: in_op, result: in_result};
      r_count <= w_count_nxt;
      r_drop  <= w_drop;
    end
  end

  assign w_head     = r_mem[w_rd_ptr];
  assign out_result = w_head.result;
  assign out_op     = w_head.op;
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);
  assign out_valid  = ~empty;
  assign in_drop    = r_drop;

`ifdef RESULT_FIFO_STATS_EN
  logic [7:0]       r_drop_cnt;
  logic [CNT_W-1:0] r_max;

  // High-water mark tracks the next count so it lines up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_max      <= '0;
    end else begin
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_count_nxt > r_max) r_max <= w_count_nxt;
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign max_count = r_max;
`endif
endmodule

// File: tb/tb_result_fifo_4bit.sv
// Self-checking bench: directed vector table, then a queue-based reference model for sequences and random traffic.
module tb_result_fifo_4bit;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0, in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
  logic [3:0] in_result = '0;
  logic       out_valid, out_op, full, empty, in_drop;
  logic [3:0] out_result;
  logic [2:0] count;
`ifdef RESULT_FIFO_STATS_EN
  logic [7:0] drop_cnt;
  logic [2:0] max_count;
`endif

  int checks = 0, failures = 0;

  result_fifo_4bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .full(full), .empty(empty), .count(count), .in_drop(in_drop)
`ifdef RESULT_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .max_count(max_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       r, iv;
    logic [3:0] d;
    logic       op, ordy;
    logic       ev;
    logic       cd;
    logic [3:0] er;
    logic       eop;
    int         ec;
    logic       edrp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the FIFO contents as a queue of {op, result}.
  logic [4:0] q[$];
  bit         m_drop;
  int         m_dcnt, m_max;

  task automatic step(input logic r, input logic iv, input logic [3:0] d,
                      input logic op, input logic ordy);
    bit pop, push;
    rst = r; in_valid = iv; in_result = d; in_op = op; out_ready = ordy;
    pop  = (q.size() != 0) && ordy;
    push = iv && ((q.size() < DEPTH) || pop);
    @(posedge clk); #1;
    if (r) begin
      q.delete(); m_drop = 0; m_dcnt = 0; m_max = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({op, d});
      m_drop = iv && !push;
      if (m_drop && m_dcnt < 255) m_dcnt++;
      if (q.size() > m_max) m_max = q.size();
    end
    chk("count", int'(count), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("in_drop", int'(in_drop), int'(m_drop));
    if (q.size() != 0) begin
      chk("out_result", int'(out_result), int'(q[0][3:0]));
      chk("out_op", int'(out_op), int'(q[0][4]));
    end
  endtask

  initial begin
    //              r  iv d     op ordy ev cd er    eop ec edrp
    tbl.push_back('{1, 0, 4'h0, 0, 0,   0, 1, 4'h0, 0,  0, 0});
    tbl.push_back('{1, 0, 4'h0, 0, 0,   0, 1, 4'h0, 0,  0, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 0,   0, 1, 4'h0, 0,  0, 0});
    tbl.push_back('{0, 1, 4'hA, 1, 0,   1, 1, 4'hA, 1,  1, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 1,   0, 0, 4'h0, 0,  0, 0});
    tbl.push_back('{0, 1, 4'h1, 0, 0,   1, 1, 4'h1, 0,  1, 0});
    tbl.push_back('{0, 1, 4'h2, 0, 0,   1, 1, 4'h1, 0,  2, 0});
    tbl.push_back('{0, 1, 4'h3, 0, 0,   1, 1, 4'h1, 0,  3, 0});
    tbl.push_back('{0, 1, 4'h4, 0, 0,   1, 1, 4'h1, 0,  4, 0});
    tbl.push_back('{0, 1, 4'h5, 0, 0,   1, 1, 4'h1, 0,  4, 1});
    tbl.push_back('{0, 0, 4'h0, 0, 0,   1, 1, 4'h1, 0,  4, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 1,   1, 1, 4'h2, 0,  3, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 1,   1, 1, 4'h3, 0,  2, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 1,   1, 1, 4'h4, 0,  1, 0});
    tbl.push_back('{0, 0, 4'h0, 0, 1,   0, 0, 4'h0, 0,  0, 0});

    foreach (tbl[i]) begin
      rst = tbl[i].r; in_valid = tbl[i].iv; in_result = tbl[i].d;
      in_op = tbl[i].op; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d.out_valid", i), int'(out_valid), int'(tbl[i].ev));
      chk($sformatf("v%0d.count", i), int'(count), tbl[i].ec);
      chk($sformatf("v%0d.full", i), int'(full), int'(tbl[i].ec == DEPTH));
      chk($sformatf("v%0d.empty", i), int'(empty), int'(tbl[i].ec == 0));
      chk($sformatf("v%0d.in_drop", i), int'(in_drop), int'(tbl[i].edrp));
      if (tbl[i].cd) begin
        chk($sformatf("v%0d.out_result", i), int'(out_result), int'(tbl[i].er));
        chk($sformatf("v%0d.out_op", i), int'(out_op), int'(tbl[i].eop));
      end
    end
`ifdef RESULT_FIFO_STATS_EN
    chk("tbl.drop_cnt", int'(drop_cnt), 1);
    chk("tbl.max_count", int'(max_count), 4);
`endif

    // Full FIFO with simultaneous push and pop; drain must be 2,3,4,9.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 4'(i), 0, 0);
    step(0, 1, 4'h9, 1, 1);
    chk("swap.count", int'(count), 4);
    chk("swap.in_drop", int'(in_drop), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // Wrap-around streaming: each entry appears one cycle after its push.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 4'(i), i[0], 1);
      chk("stream.head", int'(out_result), i);
      chk("stream.count_le1", int'(count <= 1), 1);
    end
    step(0, 0, 0, 0, 1);

    // Reset mid-operation with a push and pop pending.
    for (int i = 0; i < 3; i++) step(0, 1, 4'(i + 7), 1, 0);
    step(1, 1, 4'hC, 1, 1);
    chk("midrst.count", int'(count), 0);
    chk("midrst.empty", int'(empty), 1);
    step(0, 0, 0, 0, 1);
    chk("midrst.after_valid", int'(out_valid), 0);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
    // Long overflow run to exercise drop counting.
    for (int i = 0; i < 12; i++) step(0, 1, 4'(i), 0, 0);
`ifdef RESULT_FIFO_STATS_EN
    chk("rand.drop_cnt", int'(drop_cnt), m_dcnt);
    chk("rand.max_count", int'(max_count), m_max);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_fifo_4bit.md
Name: result_fifo_4bit

Overview:
- Buffers the 4-bit result of the 2:1 select stage, together with the op bit that chose it, in a small synchronous FIFO.
- Delivers entries to the downstream consumer with a valid/ready handshake.
- The select stage is purely combinational and has no backpressure. When the buffer is full, pushes are dropped and flagged.
- Sits directly downstream of the 4-bit mux stage.

Parameters:
- DATA_W, 4: result width; matches the mux stage output.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.
- CNT_W, 3: occupancy counter width, equal to log2(DEPTH)+1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the current in_result/in_op pair is to be captured.
- in_result  input  DATA_W  result from the mux stage.
- in_op  input  1  select bit that produced in_result; stored as a tag.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_result  output  DATA_W  head entry result.
- out_op  output  1  head entry tag.
- full  output  1  count equals DEPTH.
- empty  output  1  count equals 0.
- count  output  CNT_W  current occupancy.
- in_drop  output  1  registered one-cycle pulse: the previous cycle's push was rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd_ptr, wr_ptr and count go to 0.
  - All storage entries are cleared to 0.
  - out_valid=0, out_result=0, out_op=0, full=0, empty=1, in_drop=0.
  - Reset overrides any push or pop in the same cycle.
  - Reset mid-operation discards all contents; no entry is delivered after reset.
- Handshake definitions:
  - pop = out_valid & out_ready.
  - push = in_valid & (!full | pop). A full FIFO accepts a push in the same cycle it pops.
- Push: {in_op, in_result} is written at wr_ptr; wr_ptr advances by 1 modulo DEPTH.
- Pop: rd_ptr advances by 1 modulo DEPTH.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both, or on neither.
- Output path:
  - out_valid = !empty.
  - out_result/out_op are read combinationally from storage at rd_ptr.
  - When empty, the outputs show whatever entry sits at rd_ptr; the consumer must ignore them.
- Latency: an entry pushed on edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Empty plus in_valid: push only; no pop is possible because out_valid=0.
- Full plus in_valid plus no pop: the push is rejected, storage is unchanged, and in_drop=1 in the next cycle.
- Full plus in_valid plus pop: both occur; count stays DEPTH and in_drop=0.
- Pointer wrap-around: DEPTH-1 wraps to 0. Ordering is strict FIFO.
- Status outputs: full and empty are derived from the count register, with no combinational path from inputs.
- out_ready held high with out_valid low has no effect.

Optional Feature:
- Macro: RESULT_FIFO_STATS_EN.
- Defined:
  - Adds output drop_cnt [7:0]: a saturating count of rejected pushes. It increments in the same cycle in_drop is set and holds at 255.
  - Adds output max_count [CNT_W-1:0]: the high-water mark of count.
  - Both reset to 0 under rst.
- Not defined: neither port exists. Core behaviour is identical in both builds.

Decomposition:
- Package result_fifo_pkg holds:
  - constants DATA_W=4, DEPTH=4, CNT_W=3;
  - typedef entry_t = packed struct {op:1, result:DATA_W}.
- One sub-module, result_fifo_ptr: a modulo-DEPTH pointer register with synchronous reset and an advance enable. It is instanced twice, for rd_ptr and wr_ptr.
- Storage, count, flags and the stats logic stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 → empty=1, out_valid=0, count=0, in_drop=0, out_result=0.
- Single pass: push result=0xA, op=1 in cycle 0, out_ready=0 → in cycle 1: out_valid=1, out_result=0xA, out_op=1, count=1. Set out_ready=1 → next cycle empty=1.
- Fill and overflow: out_ready=0, push 0x1,0x2,0x3,0x4,0x5 on consecutive cycles:
  - full=1 after the 4th push;
  - the 5th push is dropped, with in_drop=1 one cycle later;
  - draining yields 0x1,0x2,0x3,0x4 only;
  - with RESULT_FIFO_STATS_EN defined, drop_cnt=1 and max_count=4.
- Full with simultaneous push and pop: FIFO full holding 0x1–0x4, out_ready=1, push 0x9 → count stays 4, in_drop=0, drain order is 0x2,0x3,0x4,0x9.
- Wrap-around streaming: out_ready=1 continuously, push 0x0..0xF on 16 consecutive cycles → outputs 0x0..0xF in order, each one cycle after its push, count never exceeds 1, no drops.
- Reset mid-operation: with 3 entries held, assert rst for one cycle alongside in_valid=1 and out_ready=1 → next cycle count=0, empty=1, in_drop=0; the pushed value is not stored.
